// File: rtl/wb_pkg.sv
// Shared encodings for the GPR writeback block: load size codes and the x0 register index.
package wb_pkg;

   localparam logic [1:0] LSU_SZ_B = 2'b00;
   localparam logic [1:0] LSU_SZ_H = 2'b01;
   localparam logic [1:0] LSU_SZ_W = 2'b10;
   localparam logic [1:0] LSU_SZ_D = 2'b11;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO of {rd, data} for ALU results; exposes per-entry valid/rd so the
// parent can build the pending-write mask.
module wb_fifo2 #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [4:0]            push_rd,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   output logic                  empty,
   output logic [4:0]            head_rd,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [1:0]            entry_valid,
   output logic [1:0][4:0]       entry_rd
);

   logic [4:0]            rd_mem [2];
   logic [DATA_WIDTH-1:0] data_mem [2];
   logic [1:0]            valid_reg;
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic                  do_push;
   logic                  do_pop;

   assign full    = valid_reg[0] & valid_reg[1];
   assign empty   = ~(valid_reg[0] | valid_reg[1]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Payload storage carries no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         rd_mem[wr_ptr_reg]   <= push_rd;
         data_mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg  <= 2'b00;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (do_push) begin
            valid_reg[wr_ptr_reg] <= 1'b1;
            wr_ptr_reg            <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            valid_reg[rd_ptr_reg] <= 1'b0;
            rd_ptr_reg            <= ~rd_ptr_reg;
         end
      end
   end

   assign head_rd     = rd_mem[rd_ptr_reg];
   assign head_data   = data_mem[rd_ptr_reg];
   assign entry_valid = valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         assign entry_rd[gi] = rd_mem[gi];
      end
   endgenerate

endmodule

// File: rtl/gpr_writeback.sv
// GPR write-port master: arbitrates buffered ALU results against unbuffered loads,
// extends load data, registers the write and publishes the pending-write mask.
module gpr_writeback
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [4:0]            alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [4:0]            lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic [1:0]            lsu_size,
   input  logic                  lsu_unsigned,
   output logic                  wen,
   output logic [4:0]            waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [31:0]           wb_pending,
   output logic [63:0]           retire_cnt
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [4:0]            head_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic [1:0]            entry_valid;
   logic [1:0][4:0]       entry_rd;

   logic                  alu_acc;
   logic                  lsu_win;
   logic                  fifo_pop;
   logic                  force_alu;
   logic                  have_winner;
   logic [4:0]            win_rd;
   logic [DATA_WIDTH-1:0] win_data;
   logic [DATA_WIDTH-1:0] lsu_ext;

   logic                  wen_reg;
   logic [4:0]            waddr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [SW-1:0]         starve_cnt_reg;
   logic [63:0]           retire_cnt_reg;

   wb_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (alu_acc),
      .pop         (fifo_pop),
      .push_rd     (alu_rd),
      .push_data   (alu_data),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   assign force_alu   = ~fifo_empty && (starve_cnt_reg >= SW'(STARVE_LIMIT));
   assign alu_ready   = ~fifo_full;
   assign lsu_ready   = ~force_alu;
   assign alu_acc     = alu_valid & alu_ready;
   assign lsu_win     = lsu_valid & lsu_ready;
   assign fifo_pop    = ~lsu_win & ~fifo_empty;
   assign have_winner = lsu_win | fifo_pop;

   always_comb begin
      lsu_ext = lsu_data;
      case (lsu_size)
         LSU_SZ_B: lsu_ext = {{(DATA_WIDTH-8){~lsu_unsigned & lsu_data[7]}}, lsu_data[7:0]};
         LSU_SZ_H: lsu_ext = {{(DATA_WIDTH-16){~lsu_unsigned & lsu_data[15]}}, lsu_data[15:0]};
         LSU_SZ_W: lsu_ext = {{(DATA_WIDTH-32){~lsu_unsigned & lsu_data[31]}}, lsu_data[31:0]};
         default:  lsu_ext = lsu_data;
      endcase
   end

   always_comb begin
      win_rd   = head_rd;
      win_data = head_data;
      if (lsu_win) begin
         win_rd   = lsu_rd;
         win_data = lsu_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_reg        <= 1'b0;
         waddr_reg      <= REG_ZERO;
         wdata_reg      <= '0;
         starve_cnt_reg <= '0;
         retire_cnt_reg <= '0;
      end else begin
         wen_reg <= have_winner && (win_rd != REG_ZERO);
         if (have_winner) begin
            waddr_reg <= win_rd;
            wdata_reg <= win_data;
         end
         if (fifo_empty || fifo_pop)
            starve_cnt_reg <= '0;
         else if (lsu_win && starve_cnt_reg < SW'(STARVE_LIMIT))
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
         retire_cnt_reg <= retire_cnt_reg + 64'(alu_acc) + 64'(lsu_win);
      end
   end

   // Mask is built from registered state only, so decode sees no input-to-output path.
   always_comb begin
      wb_pending = '0;
      for (int i = 0; i < 2; i++) begin
         if (entry_valid[i] && entry_rd[i] != REG_ZERO)
            wb_pending[entry_rd[i]] = 1'b1;
      end
      if (wen_reg)
         wb_pending[waddr_reg] = 1'b1;
   end

   assign wen        = wen_reg;
   assign waddr      = waddr_reg;
   assign wdata      = wdata_reg;
   assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: reset priority, load extension, FIFO-full
// starvation, x0 writes, simultaneous accept and mid-operation reset.
module tb_gpr_writeback;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [63:0] lsu_data;
   logic [1:0]  lsu_size;
   logic        lsu_unsigned;
   logic        wen;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic [31:0] wb_pending;
   logic [63:0] retire_cnt;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_retire;

   gpr_writeback #(.DATA_WIDTH(64), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_size     (lsu_size),
      .lsu_unsigned (lsu_unsigned),
      .wen          (wen),
      .waddr        (waddr),
      .wdata        (wdata),
      .wb_pending   (wb_pending),
      .retire_cnt   (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Advance one edge, then settle so registered outputs can be sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [63:0] d, input logic [4:0] rd, input logic [63:0] exp);
      lsu_valid    = 1'b1;
      lsu_rd       = rd;
      lsu_data     = d;
      lsu_size     = sz;
      lsu_unsigned = uns;
      tick();
      lsu_valid = 1'b0;
      exp_retire = exp_retire + 1;
      chk({tag, ".wen"}, 64'(wen), 64'd1);
      chk({tag, ".waddr"}, 64'(waddr), 64'(rd));
      chk({tag, ".wdata"}, wdata, exp);
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h11;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h22;
      lsu_size = LSU_SZ_D; lsu_unsigned = 1'b0;
      exp_retire = 64'd0;

      // Reset priority: offers during reset are never stored
      tick(); tick();
      chk("rst.alu_ready", 64'(alu_ready), 64'd1);
      chk("rst.lsu_ready", 64'(lsu_ready), 64'd1);
      chk("rst.wen", 64'(wen), 64'd0);
      chk("rst.pending", 64'(wb_pending), 64'd0);
      chk("rst.retire", retire_cnt, 64'd0);
      chk("rst.waddr", 64'(waddr), 64'd0);
      chk("rst.wdata", wdata, 64'd0);

      rst = 1'b0;
      lsu_valid = 1'b0;
      tick();
      alu_valid = 1'b0;
      exp_retire = 64'd1;
      chk("first.retire", retire_cnt, exp_retire);
      chk("first.pending", 64'(wb_pending), 64'h20);
      chk("first.wen_pre", 64'(wen), 64'd0);
      tick();
      chk("first.wen", 64'(wen), 64'd1);
      chk("first.waddr", 64'(waddr), 64'd5);
      chk("first.wdata", wdata, 64'h11);
      chk("first.pending_port", 64'(wb_pending), 64'h20);
      tick();
      chk("first.idle_wen", 64'(wen), 64'd0);
      chk("first.idle_pending", 64'(wb_pending), 64'd0);
      chk("first.hold_waddr", 64'(waddr), 64'd5);

      // Load extension
      do_load("ld_b_s", LSU_SZ_B, 1'b0, 64'h80, 5'd4, 64'hFFFF_FFFF_FFFF_FF80);
      do_load("ld_b_u", LSU_SZ_B, 1'b1, 64'h80, 5'd4, 64'h80);
      do_load("ld_h_s", LSU_SZ_H, 1'b0, 64'h8001, 5'd6, 64'hFFFF_FFFF_FFFF_8001);
      do_load("ld_w_u", LSU_SZ_W, 1'b1, 64'h8000_0000, 5'd6, 64'h0000_0000_8000_0000);
      do_load("ld_w_s_junk", LSU_SZ_W, 1'b0, 64'hDEAD_BEEF_7FFF_FFFF, 5'd31, 64'h7FFF_FFFF);
      do_load("ld_b_u_junk", LSU_SZ_B, 1'b1, 64'hAAAA_AAAA_AAAA_AA12, 5'd3, 64'h12);
      do_load("ld_d", LSU_SZ_D, 1'b0, 64'h8123_4567_89AB_CDEF, 5'd2, 64'h8123_4567_89AB_CDEF);
      chk("ld.retire", retire_cnt, exp_retire);
      tick();
      chk("ld.idle_wen", 64'(wen), 64'd0);

      // FIFO full under continuous LSU pressure, then starvation override
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h2020; lsu_size = LSU_SZ_D;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h101;
      tick();                                             // E1
      alu_rd = 5'd2; alu_data = 64'h102;
      chk("full.e1_waddr", 64'(waddr), 64'd20);
      chk("full.e1_pend1", 64'(wb_pending[2:1]), 64'b01);
      tick();                                             // E2
      alu_rd = 5'd3; alu_data = 64'h103;
      chk("full.e2_alu_ready", 64'(alu_ready), 64'd0);
      chk("full.e2_pend", 64'(wb_pending[3:1]), 64'b011);
      chk("full.e2_lsu_ready", 64'(lsu_ready), 64'd1);
      tick();                                             // E3
      tick();                                             // E4
      chk("full.e4_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("full.e4_alu_ready", 64'(alu_ready), 64'd0);
      tick();                                             // E5
      chk("full.e5_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("full.e5_waddr", 64'(waddr), 64'd20);
      exp_retire = exp_retire + 7;
      chk("full.e5_retire", retire_cnt, exp_retire);
      tick();                                             // E6
      lsu_valid = 1'b0;
      chk("full.e6_wen", 64'(wen), 64'd1);
      chk("full.e6_waddr", 64'(waddr), 64'd1);
      chk("full.e6_wdata", wdata, 64'h101);
      chk("full.e6_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("full.e6_retire", retire_cnt, exp_retire);
      chk("full.e6_pend", 64'(wb_pending), 64'h6);
      tick();                                             // E7
      alu_valid = 1'b0;
      exp_retire = exp_retire + 1;
      chk("full.e7_waddr", 64'(waddr), 64'd2);
      chk("full.e7_wdata", wdata, 64'h102);
      chk("full.e7_retire", retire_cnt, exp_retire);
      tick();                                             // E8
      chk("full.e8_waddr", 64'(waddr), 64'd3);
      chk("full.e8_wdata", wdata, 64'h103);
      tick();
      chk("full.drain_wen", 64'(wen), 64'd0);
      chk("full.drain_pend", 64'(wb_pending), 64'd0);

      // x0 destination
      alu_valid = 1'b1; alu_rd = REG_ZERO; alu_data = 64'hDEAD;
      tick();
      alu_valid = 1'b0;
      exp_retire = exp_retire + 1;
      chk("x0.retire", retire_cnt, exp_retire);
      chk("x0.pend_a", 64'(wb_pending), 64'd0);
      tick();
      chk("x0.wen", 64'(wen), 64'd0);
      chk("x0.pend_b", 64'(wb_pending), 64'd0);
      chk("x0.alu_ready", 64'(alu_ready), 64'd1);

      // Simultaneous accept from both sources
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
      lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 64'h88; lsu_size = LSU_SZ_D;
      tick();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      exp_retire = exp_retire + 2;
      chk("sim.retire", retire_cnt, exp_retire);
      chk("sim.n1_waddr", 64'(waddr), 64'd8);
      chk("sim.n1_wdata", wdata, 64'h88);
      chk("sim.n1_pend7", 64'(wb_pending[7]), 64'd1);
      tick();
      chk("sim.n2_waddr", 64'(waddr), 64'd7);
      chk("sim.n2_wdata", wdata, 64'h77);
      chk("sim.n2_pend7", 64'(wb_pending[7]), 64'd1);
      tick();
      chk("sim.n3_pend7", 64'(wb_pending[7]), 64'd0);
      chk("sim.n3_wen", 64'(wen), 64'd0);

      // Reset with two buffered entries and an active write
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hA0;
      lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 64'hB0;
      tick();
      alu_rd = 5'd12; alu_data = 64'hC0; lsu_rd = 5'd13;
      tick();
      chk("mid.pre_full", 64'(alu_ready), 64'd0);
      chk("mid.pre_wen", 64'(wen), 64'd1);
      rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("mid.wen", 64'(wen), 64'd0);
      chk("mid.pend", 64'(wb_pending), 64'd0);
      chk("mid.retire", retire_cnt, 64'd0);
      chk("mid.empty", 64'(alu_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid.no_stale_wen", 64'(wen), 64'd0);
      end
      chk("mid.retire_after", retire_cnt, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
